// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared FSM encoding, flag bit indices and ALU function codes
package alu_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLAG_CARRY = 4;
    localparam int FLAG_ARITH = 3;
    localparam int FLAG_LOGIC = 2;
    localparam int FLAG_CMP   = 1;
    localparam int FLAG_SHIFT = 0;

    localparam logic [3:0] FUN_ADD  = 4'd0;
    localparam logic [3:0] FUN_SUB  = 4'd1;
    localparam logic [3:0] FUN_MUL  = 4'd2;
    localparam logic [3:0] FUN_DIV  = 4'd3;
    localparam logic [3:0] FUN_AND  = 4'd4;
    localparam logic [3:0] FUN_OR   = 4'd5;
    localparam logic [3:0] FUN_NAND = 4'd6;
    localparam logic [3:0] FUN_NOR  = 4'd7;
    localparam logic [3:0] FUN_XOR  = 4'd8;
    localparam logic [3:0] FUN_XNOR = 4'd9;
    localparam logic [3:0] FUN_EQ   = 4'd10;
    localparam logic [3:0] FUN_GT   = 4'd11;
    localparam logic [3:0] FUN_LT   = 4'd12;
    localparam logic [3:0] FUN_SHR  = 4'd13;
    localparam logic [3:0] FUN_SHL  = 4'd14;

endpackage

// File: rtl/alu_reg_file.sv
// alu_reg_file: register file with two operand read ports, a host read port and one shared write port
module alu_reg_file #(
    parameter int DATA_W   = 16,
    parameter int RF_DEPTH = 8,
    parameter int ADDR_W   = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] rf [RF_DEPTH];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    // write-back and host writes never coincide; write-back wins regardless
    assign we    = wb_we || host_we;
    assign waddr = wb_we ? wb_addr : host_addr;
    assign wdata = wb_we ? wb_data : host_wdata;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rf <= '{default: '0};
        end else if (we) begin
            rf[waddr] <= wdata;
        end
    end

    assign rdata1     = rf[raddr1];
    assign rdata2     = rf[raddr2];
    assign host_rdata = rf[host_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts register-addressed ALU commands, drives the ALU,
// waits out its latency and writes the result back to the register file
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int FUN_W    = 4,
    parameter int RF_DEPTH = 8,
    parameter int ADDR_W   = $clog2(RF_DEPTH),
    parameter int ALU_LAT  = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [FUN_W-1:0]  CMD_FUN,
    input  logic [ADDR_W-1:0] CMD_DST,
    input  logic [ADDR_W-1:0] CMD_SRC1,
    input  logic [ADDR_W-1:0] CMD_SRC2,
    input  logic              HOST_WE,
    input  logic [ADDR_W-1:0] HOST_ADDR,
    input  logic [DATA_W-1:0] HOST_WDATA,
    output logic [DATA_W-1:0] HOST_RDATA,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic [FUN_W-1:0]  ALU_FUN,
    input  logic [DATA_W-1:0] ALU_RES,
    input  logic [4:0]        ALU_FLAGS,
    output logic              RES_VALID,
    output logic [DATA_W-1:0] RES_DATA,
    output logic [4:0]        RES_FLAGS
);

    state_e            state, state_nx;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] dst;
    logic              accept, capture;
    logic [DATA_W-1:0] rd1, rd2;

    assign CMD_READY = state == IDLE;
    assign accept    = CMD_READY && CMD_VALID;
    assign capture   = state == WAIT && cnt == 3'd0;

    alu_reg_file #(
        .DATA_W  (DATA_W),
        .RF_DEPTH(RF_DEPTH),
        .ADDR_W  (ADDR_W)
    ) u_rf (
        .CLK       (CLK),
        .RST       (RST),
        .host_we   (HOST_WE && CMD_READY),
        .host_addr (HOST_ADDR),
        .host_wdata(HOST_WDATA),
        .host_rdata(HOST_RDATA),
        .wb_we     (capture),
        .wb_addr   (dst),
        .wb_data   (ALU_RES),
        .raddr1    (CMD_SRC1),
        .raddr2    (CMD_SRC2),
        .rdata1    (rd1),
        .rdata2    (rd2)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = accept ? WAIT : capture ? DONE : state == DONE ? IDLE : state;
    end

    // operands are sampled from the pre-write RF, so aliasing dst with a source is safe
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ALU_A     <= '0;
            ALU_B     <= '0;
            ALU_FUN   <= '0;
            dst       <= '0;
            cnt       <= '0;
            RES_VALID <= 1'b0;
            RES_DATA  <= '0;
            RES_FLAGS <= '0;
        end else begin
            RES_VALID <= state == DONE;
            if (accept) begin
                ALU_A   <= rd1;
                ALU_B   <= rd2;
                ALU_FUN <= CMD_FUN;
                dst     <= CMD_DST;
                cnt     <= 3'(ALU_LAT);
            end else if (state == WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (capture) begin
                RES_DATA  <= ALU_RES;
                RES_FLAGS <= ALU_FLAGS;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with behavioural ALUs of latency 1 and 3
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic        CLK, RST;
    logic        cmd_valid0, cmd_valid3;
    logic [3:0]  cmd_fun;
    logic [2:0]  cmd_dst, cmd_src1, cmd_src2;
    logic        host_we;
    logic [2:0]  host_addr;
    logic [15:0] host_wdata;

    logic        ready0, ready3, rv0, rv3;
    logic [15:0] rdata0, rdata3, a0, a3, b0, b3, res0, res3, rdat0, rdat3;
    logic [3:0]  f0, f3;
    logic [4:0]  flg0, flg3, rflg0, rflg3;

    int n_assert = 0;
    int n_fail   = 0;

    alu_issue_ctrl #(.ALU_LAT(1)) u0 (
        .CLK(CLK), .RST(RST), .CMD_VALID(cmd_valid0), .CMD_READY(ready0),
        .CMD_FUN(cmd_fun), .CMD_DST(cmd_dst), .CMD_SRC1(cmd_src1), .CMD_SRC2(cmd_src2),
        .HOST_WE(host_we), .HOST_ADDR(host_addr), .HOST_WDATA(host_wdata), .HOST_RDATA(rdata0),
        .ALU_A(a0), .ALU_B(b0), .ALU_FUN(f0), .ALU_RES(res0), .ALU_FLAGS(flg0),
        .RES_VALID(rv0), .RES_DATA(rdat0), .RES_FLAGS(rflg0)
    );

    alu_issue_ctrl #(.ALU_LAT(3)) u3 (
        .CLK(CLK), .RST(RST), .CMD_VALID(cmd_valid3), .CMD_READY(ready3),
        .CMD_FUN(cmd_fun), .CMD_DST(cmd_dst), .CMD_SRC1(cmd_src1), .CMD_SRC2(cmd_src2),
        .HOST_WE(host_we), .HOST_ADDR(host_addr), .HOST_WDATA(host_wdata), .HOST_RDATA(rdata3),
        .ALU_A(a3), .ALU_B(b3), .ALU_FUN(f3), .ALU_RES(res3), .ALU_FLAGS(flg3),
        .RES_VALID(rv3), .RES_DATA(rdat3), .RES_FLAGS(rflg3)
    );

    // behavioural ALU returning {flags, result}
    function automatic logic [20:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
        logic [16:0] s;
        case (fun)
            FUN_ADD:  begin s = {1'b0, a} + {1'b0, b}; return {5'b11000 & {s[16], 4'b1000}, s[15:0]}; end
            FUN_SUB:  return {a < b, 4'b1000, a - b};
            FUN_MUL:  return {5'b01000, a * b};
            FUN_DIV:  return {5'b01000, b != 16'd0 ? a / b : 16'd0};
            FUN_AND:  return {5'b00100, a & b};
            FUN_OR:   return {5'b00100, a | b};
            FUN_NAND: return {5'b00100, ~(a & b)};
            FUN_NOR:  return {5'b00100, ~(a | b)};
            FUN_XOR:  return {5'b00100, a ^ b};
            FUN_XNOR: return {5'b00100, ~(a ^ b)};
            FUN_EQ:   return {5'b00010, 15'd0, a == b};
            FUN_GT:   return {5'b00010, 15'd0, a > b};
            FUN_LT:   return {5'b00010, 15'd0, a < b};
            FUN_SHR:  return {5'b00001, a >> 1};
            FUN_SHL:  return {5'b00001, a << 1};
            default:  return 21'd0;
        endcase
    endfunction

    logic [20:0] alu0_q = '0;
    logic [20:0] alu3_q [3] = '{default: '0};

    always @(posedge CLK) begin
        alu0_q    <= alu_f(a0, b0, f0);
        alu3_q[0] <= alu_f(a3, b3, f3);
        alu3_q[1] <= alu3_q[0];
        alu3_q[2] <= alu3_q[1];
    end

    assign res0 = alu0_q[15:0];
    assign flg0 = alu0_q[20:16];
    assign res3 = alu3_q[2][15:0];
    assign flg3 = alu3_q[2][20:16];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic host_wr(input logic [2:0] addr, input logic [15:0] data);
        host_we = 1'b1; host_addr = addr; host_wdata = data;
        @(negedge CLK);
        host_we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] addr, input logic [15:0] exp);
        host_addr = addr;
        #1;
        chk(tag, rdata0, exp);
    endtask

    task automatic issue(input bit sel, input logic [3:0] fun, input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
        cmd_fun = fun; cmd_dst = d; cmd_src1 = s1; cmd_src2 = s2;
        if (sel) cmd_valid3 = 1'b1;
        else cmd_valid0 = 1'b1;
        @(negedge CLK);
        cmd_valid0 = 1'b0;
        cmd_valid3 = 1'b0;
    endtask

    // counts negedges after the accept edge until RES_VALID, then checks the pulse drops
    task automatic wait_res(input string tag, input bit sel, input int start, input int exp_lat);
        int n = start;
        while (((sel ? rv3 : rv0) !== 1'b1) && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_lat"}, n, exp_lat);
        @(negedge CLK);
        chk({tag, "_pulse"}, sel ? rv3 : rv0, 0);
    endtask

    initial begin
        int n;
        RST = 1'b0; cmd_valid0 = 1'b0; cmd_valid3 = 1'b0; cmd_fun = '0; cmd_dst = '0;
        cmd_src1 = '0; cmd_src2 = '0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (2) @(negedge CLK);
        chk("rst_alu_a", a0, 0);
        chk("rst_alu_b", b0, 0);
        chk("rst_alu_fun", f0, 0);
        chk("rst_res_valid", rv0, 0);
        chk("rst_res_data", rdat0, 0);
        chk("rst_res_flags", rflg0, 0);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_ready", ready0, 1);
        rd_chk("rst_rf0", 3'd0, 16'd0);

        // add with carry out
        host_wr(3'd1, 16'hFFFF);
        host_wr(3'd2, 16'd1);
        issue(0, FUN_ADD, 3'd3, 3'd1, 3'd2);
        chk("add_busy", ready0, 0);
        chk("add_alu_a", a0, 16'hFFFF);
        chk("add_alu_b", b0, 16'd1);
        wait_res("add", 0, 0, 3);
        chk("add_data", rdat0, 16'd0);
        chk("add_flags", rflg0, 5'b11000);
        rd_chk("add_rf3", 3'd3, 16'd0);

        // back-to-back dependent chain with CMD_VALID held high
        host_wr(3'd1, 16'd6);
        host_wr(3'd2, 16'd4);
        cmd_fun = FUN_ADD; cmd_dst = 3'd3; cmd_src1 = 3'd1; cmd_src2 = 3'd2; cmd_valid0 = 1'b1;
        @(negedge CLK);
        chk("chain_acc1", ready0, 0);
        cmd_fun = FUN_SUB; cmd_dst = 3'd4; cmd_src1 = 3'd3; cmd_src2 = 3'd2;
        n = 0;
        while (rv0 !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("chain_lat1", n, 3);
        chk("chain_data1", rdat0, 16'd10);
        chk("chain_flags1", rflg0, 5'b01000);
        chk("chain_ready", ready0, 1);
        @(negedge CLK);
        cmd_valid0 = 1'b0;
        chk("chain_acc2", ready0, 0);
        chk("chain_alu_a2", a0, 16'd10);
        chk("chain_fun2", f0, FUN_SUB);
        wait_res("chain2", 0, 0, 3);
        chk("chain_data2", rdat0, 16'd6);
        chk("chain_flags2", rflg0, 5'b01000);
        rd_chk("chain_rf4", 3'd4, 16'd6);

        // aliasing dst with both sources
        host_wr(3'd5, 16'd4);
        issue(0, FUN_EQ, 3'd5, 3'd5, 3'd5);
        wait_res("eq", 0, 0, 3);
        chk("eq_data", rdat0, 16'd1);
        chk("eq_flags", rflg0, 5'b00010);
        rd_chk("eq_rf5", 3'd5, 16'd1);

        // host write dropped while busy
        host_wr(3'd1, 16'd2);
        host_wr(3'd2, 16'd2);
        issue(0, FUN_ADD, 3'd0, 3'd1, 3'd2);
        host_wr(3'd2, 16'd99);
        wait_res("busy", 0, 1, 3);
        chk("busy_data", rdat0, 16'd4);
        rd_chk("busy_rf2", 3'd2, 16'd2);

        // host write and accept in the same cycle: old operand, write still lands
        host_we = 1'b1; host_addr = 3'd1; host_wdata = 16'd7;
        issue(0, FUN_ADD, 3'd0, 3'd1, 3'd2);
        host_we = 1'b0;
        chk("same_alu_a", a0, 16'd2);
        wait_res("same", 0, 0, 3);
        chk("same_data", rdat0, 16'd4);
        rd_chk("same_rf1", 3'd1, 16'd7);

        // reset in WAIT aborts the command
        issue(0, FUN_SHL, 3'd6, 3'd1, 3'd2);
        chk("rstmid_fun", f0, FUN_SHL);
        RST = 1'b0;
        #1;
        chk("rstmid_alu_a", a0, 0);
        chk("rstmid_alu_b", b0, 0);
        chk("rstmid_alu_fun", f0, 0);
        @(negedge CLK);
        RST = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge CLK);
            if (rv0 === 1'b1) n++;
        end
        chk("rstmid_no_valid", n, 0);
        chk("rstmid_ready", ready0, 1);
        rd_chk("rstmid_rf6", 3'd6, 16'd0);

        // latency-3 ALU build
        host_wr(3'd1, 16'd6);
        host_wr(3'd2, 16'd4);
        issue(1, FUN_ADD, 3'd3, 3'd1, 3'd2);
        chk("lat3_busy", ready3, 0);
        wait_res("lat3", 1, 0, 5);
        chk("lat3_data", rdat3, 16'd10);
        chk("lat3_flags", rflg3, 5'b01000);

        // unused function code passes through with a zero result
        issue(0, 4'hF, 3'd7, 3'd1, 3'd2);
        chk("f15_fun", f0, 4'hF);
        wait_res("f15", 0, 0, 3);
        chk("f15_data", rdat0, 16'd0);
        chk("f15_flags", rflg0, 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
